// File: rtl/aes_key_sched_buf.sv
// ---------------------------------------------------------------------------
// aes_key_sched_buf
//   Iterative AES-128 key expansion with an 11-entry round-key buffer.
//   A kld strobe captures the cipher key as round key 0. The block then
//   produces one round key per clock, using the round constant supplied by
//   the external rcon generator in the same cycle. When the expansion is
//   complete, ready is raised. The inverse cipher can then read any round
//   key by index, with one cycle of read latency.
//
// Ports
//   clk      in   1    system clock, rising edge
//   rst      in   1    asynchronous active-high reset
//   kld      in   1    key load strobe (shared with the rcon generator)
//   key      in   128  cipher key, key[127:96] = w0
//   rcon     in   32   round constant for the current expansion step
//   rd_addr  in   4    round-key index to read (0..10; 11..15 read as 0)
//   rd_key   out  128  registered round key read data
//   busy     out  1    expansion in progress
//   ready    out  1    all 11 round keys valid
//
// Also contains aes_sbox, the combinational AES S-box used for SubWord.
// ---------------------------------------------------------------------------

module aes_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);
  // The S-box is computed arithmetically: first the GF(2^8) inverse, then
  // the affine transform. This avoids a 256-entry constant table.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  logic [7:0] w_a2, w_a3, w_a12, w_a15, w_a240, w_inv;

  // The inverse is computed as a^254 with a short addition chain.
  // Zero maps to zero, as AES requires.
  always_comb begin
    logic [7:0] t;
    w_a2   = gmul(i_in, i_in);
    w_a3   = gmul(w_a2, i_in);
    t      = gmul(w_a3, w_a3);          // a^6
    w_a12  = gmul(t, t);                // a^12
    w_a15  = gmul(w_a12, w_a3);         // a^15
    t      = gmul(w_a15, w_a15);        // a^30
    t      = gmul(t, t);                // a^60
    t      = gmul(t, t);                // a^120
    w_a240 = gmul(t, t);                // a^240
    t      = gmul(w_a240, w_a12);       // a^252
    w_inv  = gmul(t, w_a2);             // a^254
  end

  assign o_out = w_inv
               ^ {w_inv[6:0], w_inv[7]}
               ^ {w_inv[5:0], w_inv[7:6]}
               ^ {w_inv[4:0], w_inv[7:5]}
               ^ {w_inv[3:0], w_inv[7:4]}
               ^ 8'h63;
endmodule

module aes_key_sched_buf #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         kld,
  input  logic [127:0] key,
  input  logic [31:0]  rcon,
  input  logic [3:0]   rd_addr,
  output logic [127:0] rd_key,
  output logic         busy,
  output logic         ready
);
  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t         r_state, w_state_next;
  logic [3:0]     r_cnt, w_cnt_next;
  logic           r_busy, w_busy_next;
  logic           r_ready, w_ready_next;
  logic           w_step;
  logic [127:0]   r_w;
  logic [127:0]   r_rk [0:NR];
  logic [127:0]   r_rd_key;

  // Current expansion words and the next round key.
  logic [31:0]    w_w0, w_w1, w_w2, w_w3;
  logic [31:0]    w_rot, w_sub, w_t;
  logic [31:0]    w_n0, w_n1, w_n2, w_n3;
  logic [127:0]   w_next_key;

  assign {w_w0, w_w1, w_w2, w_w3} = r_w;
  assign w_rot = {w_w3[23:0], w_w3[31:24]};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_subword
      aes_sbox u_sbox (
        .i_in  (w_rot[8*gi +: 8]),
        .o_out (w_sub[8*gi +: 8])
      );
    end
  endgenerate

  // rcon is used directly in this cycle. The generator has already
  // stepped to the constant for round r_cnt.
  assign w_t        = w_sub ^ rcon;
  assign w_n0       = w_w0 ^ w_t;
  assign w_n1       = w_w1 ^ w_n0;
  assign w_n2       = w_w2 ^ w_n1;
  assign w_n3       = w_w3 ^ w_n2;
  assign w_next_key = {w_n0, w_n1, w_n2, w_n3};

  // Next-state logic. kld has priority in every state, so a new key
  // restarts an expansion that is still running.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_busy_next  = r_busy;
    w_ready_next = r_ready;
    w_step       = 1'b0;
    if (kld) begin
      w_state_next = S_EXPAND;
      w_cnt_next   = 4'd1;
      w_busy_next  = 1'b1;
      w_ready_next = 1'b0;
    end else begin
      case (r_state)
        S_EXPAND: begin
          w_step = 1'b1;
          if (r_cnt == 4'(NR)) begin
            // Last round key is written on this edge. cnt stays at NR.
            w_state_next = S_DONE;
            w_busy_next  = 1'b0;
            w_ready_next = 1'b1;
          end else begin
            w_cnt_next = r_cnt + 4'd1;
          end
        end
        default: ;  // IDLE and DONE hold everything
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_busy  <= 1'b0;
      r_ready <= 1'b0;
      r_w     <= '0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_busy  <= w_busy_next;
      r_ready <= w_ready_next;
      if (kld)
        r_w <= key;
      else if (w_step)
        r_w <= w_next_key;
    end
  end

  // Each buffer entry has its own write enable. Entry 0 is loaded by kld.
  // Entries 1..NR are loaded by the expansion step whose counter matches.
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_rk
      logic w_we;
      logic [127:0] w_wdata;
      if (gi == 0) begin : g_load
        assign w_we    = kld;
        assign w_wdata = key;
      end else begin : g_exp
        assign w_we    = w_step && (r_cnt == 4'(gi));
        assign w_wdata = w_next_key;
      end
      always_ff @(posedge clk or posedge rst) begin
        if (rst)
          r_rk[gi] <= '0;
        else if (w_we)
          r_rk[gi] <= w_wdata;
      end
    end
  endgenerate

  // Registered read with no write bypass. A read on the same edge as a
  // write to that entry returns the old contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_rd_key <= '0;
    else if (rd_addr <= 4'(NR))
      r_rd_key <= r_rk[rd_addr];
    else
      r_rd_key <= '0;
  end

  assign rd_key = r_rd_key;
  assign busy   = r_busy;
  assign ready  = r_ready;
endmodule

// File: doc/aes_key_sched_buf.md
Name: aes_key_sched_buf

Overview:
- Iterative AES-128 key schedule that consumes the round-constant stream from the rcon generator.
- Expands one 128-bit cipher key into all 11 round keys, one round per clock, and stores them in an internal buffer.
- The inverse cipher reads round keys by index in any order, typically 10 down to 0.
- Sits between the rcon generator and the inverse cipher datapath.

Parameters:
- NR, 10, number of expansion rounds. Fixed for AES-128; only 10 is supported.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- kld  in  1  key load strobe. Must be driven from the same source as the rcon generator's kld.
- key  in  128  cipher key, sampled when kld=1. key[127:96] is word w0.
- rcon  in  32  round constant from the rcon generator; only [31:24] is non-zero
- rd_addr  in  4  round-key index to read, 0..10
- rd_key  out  128  registered read data
- busy  out  1  expansion in progress
- ready  out  1  all 11 round keys valid

Behaviour:
- Reset (asynchronous):
  - state=IDLE, cnt=0, w=0.
  - All 11 buffer entries = 0.
  - rd_key=0, busy=0, ready=0.
- States: IDLE, EXPAND, DONE.
- kld=1 at an edge, in any state:
  - w<=key, rk[0]<=key, cnt<=1, state<=EXPAND.
  - busy<=1, ready<=0.
  - kld has priority over everything else, so it restarts an expansion in progress.
- Rcon alignment: the rcon generator presents 0x01000000 on the first cycle after kld, then 0x02, 0x04, ... 0x36 on successive cycles. This block uses rcon combinationally in that same cycle with no extra delay.
- EXPAND, each cycle with kld=0:
  - t = SubWord(RotWord(w3)) ^ rcon, where RotWord(x) = {x[23:0], x[31:24]}.
  - SubWord = four instances of the existing combinational aes_sbox, one per byte.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - w<={n0,n1,n2,n3}, rk[cnt]<={n0,n1,n2,n3}, cnt<=cnt+1.
- End of expansion: when cnt==10 the write completes, then state<=DONE, busy<=0, ready<=1.
  - Timing: kld at edge T gives ready=1 after edge T+10.
- DONE:
  - Holds the buffer and ready until the next kld or reset.
  - w and cnt do not change.
  - The rcon input is ignored.
- IDLE: no buffer writes.
- Read path:
  - rd_key <= rk[rd_addr] on every edge, in every state (1-cycle latency).
  - rd_addr 11..15 gives rd_key=0.
  - Reads during EXPAND return the current buffer contents: 0 or stale values for entries not yet rewritten. Consumers must wait for ready.
- Same-cycle read and write: a read of an entry written on the same edge returns the old value (no bypass).
- cnt is 4 bits and never exceeds 10; no wrap-around occurs.
- Mid-operation reset: rst asserted during EXPAND clears everything immediately. An expansion already in progress does not resume afterwards.

Test Plan:
- Reset state: hold rst, then release -> busy=0, ready=0, rd_key=0; reading addresses 0..10 returns 0.
- FIPS-197 key vector:
  - Stimulus: key=2b7e151628aed2a6abf7158809cf4f3c, kld pulse with a live rcon generator.
  - ready rises exactly 10 cycles after the kld edge.
  - rk[0]=2b7e151628aed2a6abf7158809cf4f3c, rk[1]=a0fafe1788542cb123a339392a6c7605, rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse read: after ready, sweep rd_addr 10 down to 0, one per cycle -> rd_key matches the FIPS round keys, each delayed by one cycle; rd_addr=12 -> 0.
- Restart: second kld with key=000102030405060708090a0b0c0d0e0f issued 4 cycles into expansion -> ready drops; 10 cycles later ready=1 and rk[10]=13111d7fe3944a17f307a78b4d2b30c5.
- Asynchronous reset mid-EXPAND (cycle 5): outputs and buffer clear immediately, without waiting for clk; the block stays in IDLE until the next kld.
- Hold in DONE: after ready, toggle rcon randomly for 20 cycles with kld=0 -> buffer contents unchanged and ready stays 1.
